// File: rtl/sobel_pkg.sv
// Shared types and default image geometry for the Sobel scheduler and line buffer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } sched_state_t;

  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;

  // First row/column index whose accept completes a 3x3 window.
  localparam int unsigned WIN_EDGE = 2;

endpackage

// File: rtl/sobel_window_sched_if.sv
// Pixel bus / window handshake between the bus, the scheduler and the calculator.
interface sobel_window_sched_if
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic             frame_start;
  logic             pix_valid;
  logic             calc_busy;
  logic             pix_ready;
  logic             shift_en;
  logic             win_valid;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  logic             busy;
  logic             frame_done;

  modport master (
    output frame_start, pix_valid, calc_busy,
    input  pix_ready, shift_en, win_valid, win_col, win_row, busy, frame_done
  );

  modport slave (
    input  frame_start, pix_valid, calc_busy,
    output pix_ready, shift_en, win_valid, win_col, win_row, busy, frame_done
  );

endinterface

// File: rtl/sched_coord_counter.sv
// Wrap counter for one raster coordinate; at_wrap flags the last position.
module sched_coord_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_en,
  input  logic [W-1:0] wrap_val,
  output logic [W-1:0] count,
  output logic         at_wrap
);

  assign at_wrap = (count == wrap_val);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= at_wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/sobel_window_sched.sv
// Raster-scan scheduler: accepts pixels, tracks position, flags complete 3x3 windows.
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input logic                 clk,
  input logic                 n_rst,
  sobel_window_sched_if.slave bus
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  sched_state_t     state;
  sched_state_t     state_next;
  logic             clear;
  logic             pix_ready_c;
  logic             accept;
  logic             frame_last;
  logic             win_hit;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_at_wrap;
  logic             row_at_wrap;
  logic             win_valid_q;
  logic [COL_W-1:0] win_col_q;
  logic [ROW_W-1:0] win_row_q;
  logic             busy_q;
  logic             frame_done_q;

  // Stall the bus whenever the calculator cannot take another window.
  assign pix_ready_c = (state == STREAM) && !bus.calc_busy;
  assign accept      = bus.pix_valid && pix_ready_c;
  assign frame_last  = col_at_wrap && row_at_wrap;
  assign win_hit     = accept && (col >= COL_W'(WIN_EDGE)) && (row >= ROW_W'(WIN_EDGE));

  sched_coord_counter #(.W(COL_W)) u_col (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .count_en (accept),
    .wrap_val (COL_LAST),
    .count    (col),
    .at_wrap  (col_at_wrap)
  );

  sched_coord_counter #(.W(ROW_W)) u_row (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .count_en (accept && col_at_wrap),
    .wrap_val (ROW_LAST),
    .count    (row),
    .at_wrap  (row_at_wrap)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; counters clear on the transition into STREAM.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          state_next = STREAM;
          clear      = 1'b1;
        end
      end
      STREAM: begin
        if (accept && frame_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags track the state they describe, one register per output.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      busy_q       <= (state_next != IDLE);
      frame_done_q <= (state_next == DONE);
    end
  end

  // Window center trails the completing accept by one row and one column.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      win_valid_q <= win_hit;
      if (win_hit) begin
        win_col_q <= col - COL_W'(1);
        win_row_q <= row - ROW_W'(1);
      end
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.shift_en   = accept;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_sched.sv
// Directed bench: 4x4, 5x3 and default-size schedulers driven from scenario tasks.
module tb_sobel_window_sched;

  logic clk = 1'b0;
  logic n_rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sobel_window_sched_if #(.IMG_W(4), .IMG_H(4)) ia ();
  sobel_window_sched_if #(.IMG_W(5), .IMG_H(3)) ib ();
  sobel_window_sched_if                         ic ();

  sobel_window_sched #(.IMG_W(4), .IMG_H(4)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ia));
  sobel_window_sched #(.IMG_W(5), .IMG_H(3)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ib));
  sobel_window_sched                         dut_c (.clk(clk), .n_rst(n_rst), .bus(ic));

  // Results of the most recent frame run.
  int acc, nwin, tim_bad, stall_bad, stalls, done_seen, done_ok, busy_first;
  int wc[8];
  int wr[8];

  // Run one 4x4 frame; bp = cycles of calc_busy starting at each win_valid.
  task automatic run_a(input int bp, input bit drop);
    int hold, pc, pr, mc, mr;
    bit pend, prev_acc;
    acc = 0; nwin = 0; tim_bad = 0; stall_bad = 0; stalls = 0;
    done_seen = 0; done_ok = 0; busy_first = 0;
    for (int i = 0; i < 8; i++) begin wc[i] = -1; wr[i] = -1; end
    hold = 0; pc = 0; pr = 0; mc = 0; mr = 0; pend = 1'b0; prev_acc = 1'b0;
    @(negedge clk); ia.frame_start = 1'b1;
    @(negedge clk); ia.frame_start = 1'b0; ia.pix_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && done_seen == 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ia.win_valid !== pend) tim_bad++;
      if (ia.win_valid === 1'b1) begin
        if (ia.win_col !== 2'(pc) || ia.win_row !== 2'(pr)) tim_bad++;
        if (nwin < 8) begin wc[nwin] = int'(ia.win_col); wr[nwin] = int'(ia.win_row); end
        nwin++;
        hold = bp;
      end
      if (cyc == 0) busy_first = int'(ia.busy);
      ia.calc_busy = (hold > 0);
      if (hold > 0) hold--;
      ia.frame_start = drop && (cyc == 3);
      #1;
      if (ia.frame_done === 1'b1) begin
        done_seen = 1;
        done_ok   = (prev_acc && acc == 16) ? 1 : 0;
        if (ia.shift_en !== 1'b0 || ia.pix_ready !== 1'b0) stall_bad++;
        if (drop) ia.frame_start = 1'b1;
      end else begin
        if (ia.pix_ready !== !ia.calc_busy) stall_bad++;
        if (ia.calc_busy === 1'b1) stalls++;
      end
      pend     = 1'b0;
      prev_acc = (ia.shift_en === 1'b1);
      if (prev_acc) begin
        acc++;
        if (mr >= 2 && mc >= 2) begin pend = 1'b1; pc = mc - 1; pr = mr - 1; end
        if (mc == 3) begin mc = 0; mr++; end else mc++;
      end
    end
    ia.pix_valid = 1'b0;
    ia.calc_busy = 1'b0;
  endtask

  task automatic check_frame_a(input string tag, input int exp_stalls);
    int er[4];
    int ec[4];
    er = '{1, 1, 2, 2};
    ec = '{1, 2, 1, 2};
    checks++;
    if (busy_first !== 1) begin failures++; $display("FAIL %s_busy_start got=%0d exp=1", tag, busy_first); end
    checks++;
    if (acc !== 16) begin failures++; $display("FAIL %s_accepts got=%0d exp=16", tag, acc); end
    checks++;
    if (nwin !== 4) begin failures++; $display("FAIL %s_windows got=%0d exp=4", tag, nwin); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr[i] !== er[i] || wc[i] !== ec[i]) begin
        failures++;
        $display("FAIL %s_center%0d got=(%0d,%0d) exp=(%0d,%0d)", tag, i, wr[i], wc[i], er[i], ec[i]);
      end
    end
    checks++;
    if (tim_bad !== 0) begin failures++; $display("FAIL %s_win_timing got=%0d errors exp=0", tag, tim_bad); end
    checks++;
    if (stall_bad !== 0) begin failures++; $display("FAIL %s_pix_ready got=%0d errors exp=0", tag, stall_bad); end
    checks++;
    if (stalls !== exp_stalls) begin failures++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", tag, stalls, exp_stalls); end
    checks++;
    if (done_seen !== 1 || done_ok !== 1) begin
      failures++;
      $display("FAIL %s_frame_done got seen=%0d after_last=%0d exp=1/1", tag, done_seen, done_ok);
    end
  endtask

  task automatic test_reset;
    int n, gc, gr, fd;
    bit got;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ic.pix_ready, ic.shift_en, ic.win_valid, ic.busy, ic.frame_done} !== 5'b0 ||
        ic.win_col !== 6'd0 || ic.win_row !== 6'd0) begin
      failures++; $display("FAIL reset_initial_outputs busy=%b ready=%b exp all 0", ic.busy, ic.pix_ready);
    end
    n_rst = 1'b1;
    @(negedge clk); ic.frame_start = 1'b1;
    @(negedge clk); ic.frame_start = 1'b0; ic.pix_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({ic.pix_ready, ic.shift_en, ic.win_valid, ic.busy, ic.frame_done} !== 5'b0 ||
        ic.win_col !== 6'd0 || ic.win_row !== 6'd0) begin
      failures++;
      $display("FAIL reset_midframe ready=%b shift=%b win=%b busy=%b done=%b exp all 0",
               ic.pix_ready, ic.shift_en, ic.win_valid, ic.busy, ic.frame_done);
    end
    n_rst = 1'b1; ic.pix_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ic.busy !== 1'b0 || ic.frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_stays_idle busy=%b done=%b exp 0/0", ic.busy, ic.frame_done);
    end
    @(negedge clk); ic.frame_start = 1'b1;
    @(negedge clk); ic.frame_start = 1'b0; ic.pix_valid = 1'b1;
    n = 0; gc = -1; gr = -1; fd = 0; got = 1'b0;
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ic.win_valid === 1'b1) begin
        got = 1'b1; gc = int'(ic.win_col); gr = int'(ic.win_row);
      end else begin
        #1;
        if (ic.shift_en === 1'b1) n++;
        if (ic.frame_done === 1'b1) fd++;
      end
    end
    ic.pix_valid = 1'b0;
    checks++;
    if (!got || n !== 131) begin failures++; $display("FAIL restart_first_window got_accepts=%0d seen=%0d exp=131", n, got); end
    checks++;
    if (gr !== 1 || gc !== 1) begin failures++; $display("FAIL restart_center got=(%0d,%0d) exp=(1,1)", gr, gc); end
    checks++;
    if (fd !== 0) begin failures++; $display("FAIL restart_no_done got=%0d exp=0", fd); end
    n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full;
    run_a(0, 1'b0);
    check_frame_a("full", 0);
    @(negedge clk); #1;
    checks++;
    if (ia.busy !== 1'b0 || ia.frame_done !== 1'b0) begin
      failures++; $display("FAIL full_back_to_idle busy=%b done=%b exp 0/0", ia.busy, ia.frame_done);
    end
  endtask

  task automatic test_backpressure;
    run_a(3, 1'b0);
    check_frame_a("bp", 9);
  endtask

  task automatic test_bursty;
    int pc, pr, mc, mr, n, nw, bad, dok;
    int er[3];
    int ecl[3];
    bit pend, prev_acc, dseen;
    er  = '{1, 1, 1};
    ecl = '{1, 2, 3};
    pc = 0; pr = 0; mc = 0; mr = 0; n = 0; nw = 0; bad = 0; dok = 0;
    pend = 1'b0; prev_acc = 1'b0; dseen = 1'b0;
    @(negedge clk); ib.frame_start = 1'b1;
    @(negedge clk); ib.frame_start = 1'b0;
    for (int cyc = 0; cyc < 200 && !dseen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ib.win_valid !== pend) bad++;
      if (ib.win_valid === 1'b1) begin
        if (nw < 3 && (ib.win_row !== 2'(er[nw]) || ib.win_col !== 3'(ecl[nw]))) bad++;
        if (ib.win_row !== 2'(pr) || ib.win_col !== 3'(pc)) bad++;
        nw++;
      end
      ib.pix_valid = (cyc % 2 == 0);
      #1;
      if (ib.frame_done === 1'b1) begin
        dseen = 1'b1;
        dok   = (prev_acc && n == 15) ? 1 : 0;
      end else if (ib.shift_en !== ib.pix_valid) begin
        bad++;
      end
      pend     = 1'b0;
      prev_acc = (ib.shift_en === 1'b1);
      if (prev_acc) begin
        n++;
        if (mr >= 2 && mc >= 2) begin pend = 1'b1; pc = mc - 1; pr = mr - 1; end
        if (mc == 4) begin mc = 0; mr++; end else mc++;
      end
    end
    ib.pix_valid = 1'b0;
    checks++;
    if (n !== 15) begin failures++; $display("FAIL bursty_accepts got=%0d exp=15", n); end
    checks++;
    if (nw !== 3) begin failures++; $display("FAIL bursty_windows got=%0d exp=3", nw); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bursty_timing got=%0d errors exp=0", bad); end
    checks++;
    if (dok !== 1) begin failures++; $display("FAIL bursty_frame_done got=%0d exp=1", dok); end
  endtask

  task automatic test_dropped_start;
    run_a(0, 1'b1);
    check_frame_a("drop", 0);
    @(negedge clk); ia.frame_start = 1'b0; #1;
    checks++;
    if (ia.busy !== 1'b0) begin failures++; $display("FAIL drop_idle_after_done busy=%b exp=0", ia.busy); end
    @(negedge clk); #1;
    checks++;
    if (ia.busy !== 1'b0 || ia.pix_ready !== 1'b0) begin
      failures++; $display("FAIL drop_no_restart busy=%b ready=%b exp 0/0", ia.busy, ia.pix_ready);
    end
  endtask

  task automatic test_back_to_back;
    run_a(0, 1'b0);
    check_frame_a("b2b_first", 0);
    run_a(0, 1'b0);
    check_frame_a("b2b_second", 0);
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0;
    ia.frame_start = 1'b0; ia.pix_valid = 1'b0; ia.calc_busy = 1'b0;
    ib.frame_start = 1'b0; ib.pix_valid = 1'b0; ib.calc_busy = 1'b0;
    ic.frame_start = 1'b0; ic.pix_valid = 1'b0; ic.calc_busy = 1'b0;
    test_reset;
    test_full;
    test_backpressure;
    test_bursty;
    test_dropped_start;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
